// File: rtl/jtbubl_rom_sched_if.sv
// Bus bundle for the ROM scheduler: four cached read slots plus the SDRAM read port.
// Latency: none, this is a signal container only.
// Backpressure: sdram_ack holds a request; a slot's ok stays low until its fill lands.
interface jtbubl_rom_sched_if #(
    parameter int AW = 22
);
    // Slot side, index 0..3 = main, sub, sound, GFX
    logic [3:0]           slot_cs;
    logic [3:0][AW-1:0]   slot_addr;
    logic [3:0]           slot_ok;
    logic [3:0][31:0]     slot_dout;
    // Video / download status
    logic                 LVBL;
    logic                 downloading;
    // SDRAM side
    logic                 sdram_req;
    logic [AW-1:0]        sdram_addr;
    logic                 sdram_ack;
    logic                 data_rdy;
    logic [31:0]          data_read;
    logic                 refresh_en;

    // Scheduler side
    modport master (
        input  slot_cs, slot_addr, LVBL, downloading, sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );

    // Environment side: CPUs, video and the SDRAM controller
    modport slave (
        output slot_cs, slot_addr, LVBL, downloading, sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );
endinterface

// File: rtl/jtbubl_rom_sched.sv
// Four-slot single-word ROM cache with round-robin SDRAM fetch scheduling (GFX can preempt in active video).
// Latency: grant in IDLE at t, sdram_req from t+1; slot ok rises the cycle after data_rdy.
// Backpressure: sdram_req held until sdram_ack; one fetch in flight, misses wait their turn.
module jtbubl_rom_sched #(
    parameter int AW       = 22,
    parameter bit GFX_PRIO = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    jtbubl_rom_sched_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [3:0][AW-1:0] r_tag;
    logic [3:0][31:0]   r_data;
    logic [3:0]         r_valid;
    logic [1:0]         r_ptr;      // last granted slot
    logic [1:0]         r_gnt;      // slot owning the in-flight fetch
    logic [AW-1:0]      r_addr;     // latched fetch address

    logic [3:0]         w_ok;
    logic [3:0]         w_pend;
    logic               w_any_pend;
    logic [1:0]         w_sel;
    logic [1:0]         w_cand;
    logic               w_grant;
    logic               w_fill;

    // Hit detection: a slot is served straight from its entry when the tag matches the live address
    always_comb begin
        w_ok = '0;
        for (int i = 0; i < 4; i++) begin
            w_ok[i] = bus.slot_cs[i] & r_valid[i] & (r_tag[i] == bus.slot_addr[i]);
        end
    end

    assign w_pend     = bus.slot_cs & ~w_ok;
    assign w_any_pend = |w_pend;

    // Winner selection: first pending slot after the last grant, GFX jumps the queue during active video
    always_comb begin
        w_sel  = r_ptr;
        w_cand = r_ptr;
        // Walk from farthest to nearest so the nearest pending slot wins
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (w_pend[w_cand]) begin
                w_sel = w_cand;
            end
        end
        if (GFX_PRIO && bus.LVBL && w_pend[3]) begin
            w_sel = 2'd3;
        end
    end

    // Next-state logic: grant only from IDLE, so a fill and the following grant never share a cycle
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.downloading && w_any_pend) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.sdram_ack) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.data_rdy) begin
                    w_fill      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any fetch in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: address and owner stay frozen until the fetch returns
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= '0;
            r_gnt  <= 2'd0;
            r_ptr  <= 2'd3;
        end else if (w_grant) begin
            r_addr <= bus.slot_addr[w_sel];
            r_gnt  <= w_sel;
            r_ptr  <= w_sel;
        end
    end

    // Cache fill: tag takes the latched address, so a slot that moved on keeps missing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tag  <= '0;
            r_data <= '0;
        end else if (w_fill) begin
            r_tag[r_gnt]  <= r_addr;
            r_data[r_gnt] <= bus.data_read;
        end
    end

    // Valid bits: a ROM download invalidates everything, including a fill landing that cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
        end else if (bus.downloading) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[r_gnt] <= 1'b1;
        end
    end

    assign bus.slot_ok    = w_ok;
    assign bus.slot_dout  = r_data;
    assign bus.sdram_req  = (r_state == S_REQ);
    assign bus.sdram_addr = r_addr;
    // Refresh allowed whenever the scheduler has nothing to do, during download, or while held in reset
    assign bus.refresh_en = ~rstn | bus.downloading | ((r_state == S_IDLE) & ~w_any_pend);

endmodule

// File: tb/tb_jtbubl_rom_sched.sv
// Bench for jtbubl_rom_sched: table of arbitration vectors, hand sequences, random run against a model.
// Latency: n/a.
// Backpressure: SDRAM responder with programmable ack/data delays.
module tb_jtbubl_rom_sched;
    localparam int AW = 22;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    jtbubl_rom_sched_if #(.AW(AW)) bus ();

    jtbubl_rom_sched #(.AW(AW), .GFX_PRIO(1'b1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SDRAM responder ----------------
    int          ack_dly   = 2;
    int          rdy_dly   = 3;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_dat = 32'h0;
    int          n_req     = 0;

    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        return 32'h9E3779B9 * 32'(a) + 32'h01234567;
    endfunction

    initial begin
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = '0;
        forever begin
            @(negedge clk);
            if (bus.sdram_req) begin
                n_req++;
                for (int k = 1; k < ack_dly; k++) @(negedge clk);
                if (bus.sdram_req) begin
                    bus.sdram_ack = 1'b1;
                    @(negedge clk);
                    bus.sdram_ack = 1'b0;
                    for (int k = 1; k < rdy_dly; k++) @(negedge clk);
                    bus.data_read = use_fixed ? fixed_dat : mem(bus.sdram_addr);
                    bus.data_rdy  = 1'b1;
                    @(negedge clk);
                    bus.data_rdy  = 1'b0;
                end
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [3:0][AW-1:0] m_tag   = '0;
    logic [3:0][31:0]   m_dat   = '0;
    logic [3:0]         m_val   = '0;
    logic               m_busy  = 1'b0;
    logic               m_acked = 1'b0;
    int                 m_last  = 3;
    int                 m_g     = 0;
    logic [AW-1:0]      m_gaddr = '0;

    function automatic logic [3:0] m_pend();
        logic [3:0] p;
        for (int i = 0; i < 4; i++)
            p[i] = bus.slot_cs[i] && !(m_val[i] && (m_tag[i] == bus.slot_addr[i]));
        return p;
    endfunction

    task automatic model_step();
        logic [3:0] p;
        int g;
        if (!rstn) begin
            m_tag = '0; m_dat = '0; m_val = '0;
            m_busy = 1'b0; m_acked = 1'b0; m_last = 3; m_gaddr = '0;
            return;
        end
        p = m_pend();
        if (m_busy) begin
            if (m_acked) begin
                if (bus.data_rdy) begin
                    m_tag[m_g] = m_gaddr;
                    m_dat[m_g] = bus.data_read;
                    m_val[m_g] = 1'b1;
                    m_busy     = 1'b0;
                end
            end else if (bus.sdram_ack) begin
                m_acked = 1'b1;
            end
        end else if (!bus.downloading && p != 4'b0) begin
            g = -1;
            if (bus.LVBL && p[3]) g = 3;
            else
                for (int k = 1; k <= 4 && g < 0; k++)
                    if (p[(m_last + k) % 4]) g = (m_last + k) % 4;
            m_g     = g;
            m_last  = g;
            m_gaddr = bus.slot_addr[g];
            m_busy  = 1'b1;
            m_acked = 1'b0;
        end
        if (bus.downloading) m_val = '0;
    endtask

    task automatic check_outputs();
        logic [3:0] p;
        p = m_pend();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mdl_ok%0d", i), 64'(bus.slot_ok[i]),
                64'(bus.slot_cs[i] & m_val[i] & (m_tag[i] == bus.slot_addr[i])));
            chk($sformatf("mdl_dout%0d", i), 64'(bus.slot_dout[i]), 64'(m_dat[i]));
        end
        chk("mdl_sdram_req", 64'(bus.sdram_req), 64'(m_busy & ~m_acked));
        if (m_busy) chk("mdl_sdram_addr", 64'(bus.sdram_addr), 64'(m_gaddr));
        chk("mdl_refresh_en", 64'(bus.refresh_en), 64'(bus.downloading | (~m_busy & (p == 4'b0))));
    endtask

    // Sample just before each rising edge, then advance the model across that edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rstn) check_outputs();
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.slot_cs = '0;
        bus.downloading = 1'b0;
        bus.LVBL = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // which: 0 sdram_req, 1 sdram_ack, 2 data_rdy, 3 slot_ok==mask
    task automatic wait_sig(input string name, input int which, input logic [3:0] mask, input int budget);
        bit hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            #4;
            case (which)
                0:       hit = bus.sdram_req;
                1:       hit = bus.sdram_ack;
                2:       hit = bus.data_rdy;
                default: hit = (bus.slot_ok == mask);
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: timeout got none want event within %0d cycles", name, budget);
        end
    endtask

    task automatic run_grants(input int n, output logic [3:0][1:0] got, output int cnt);
        logic prev = 1'b0;
        int   g;
        got = '0;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < n; c++) begin
            @(negedge clk);
            #4;
            if (bus.sdram_req && !prev) begin
                g = 3;
                for (int j = 0; j < 4; j++)
                    if (bus.slot_addr[j] == bus.sdram_addr) g = j;
                got[cnt] = 2'(g);
                cnt++;
            end
            prev = bus.sdram_req;
        end
    endtask

    typedef struct {
        logic [3:0]       cs;
        logic             lvbl;
        int               n;
        logic [3:0][1:0]  order;
    } vec_t;

    function automatic vec_t mk(logic [3:0] cs, logic lv, int n, int o0, int o1, int o2, int o3);
        vec_t v;
        v.cs = cs; v.lvbl = lv; v.n = n;
        v.order[0] = 2'(o0); v.order[1] = 2'(o1); v.order[2] = 2'(o2); v.order[3] = 2'(o3);
        return v;
    endfunction

    vec_t            vecs [8];
    logic [3:0][1:0] got;
    int              cnt;
    int              base;
    int              s;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = mk(4'b0111, 1'b0, 3, 0, 1, 2, 0);
        vecs[1] = mk(4'b1001, 1'b1, 2, 3, 0, 0, 0);
        vecs[2] = mk(4'b1001, 1'b0, 2, 0, 3, 0, 0);
        vecs[3] = mk(4'b1111, 1'b0, 4, 0, 1, 2, 3);
        vecs[4] = mk(4'b1111, 1'b1, 4, 3, 0, 1, 2);
        vecs[5] = mk(4'b0110, 1'b0, 2, 1, 2, 0, 0);
        vecs[6] = mk(4'b1100, 1'b0, 2, 2, 3, 0, 0);
        vecs[7] = mk(4'b1010, 1'b1, 2, 3, 1, 0, 0);

        // Reset state, with every slot requesting address 0 against cleared tags
        bus.slot_cs = 4'b1111; bus.slot_addr = '0; bus.LVBL = 1'b0; bus.downloading = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 64'(bus.sdram_req), 64'd0);
        chk("rst_addr", 64'(bus.sdram_addr), 64'd0);
        chk("rst_refresh", 64'(bus.refresh_en), 64'd1);
        chk("rst_ok", 64'(bus.slot_ok), 64'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_dout%0d", i), 64'(bus.slot_dout[i]), 64'd0);
        bus.slot_cs = '0;
        @(negedge clk);
        rstn = 1'b1;

        // Arbitration table, each vector from a fresh reset
        for (int v = 0; v < 8; v++) begin
            do_reset();
            ack_dly = 1 + v % 3;
            rdy_dly = 1 + v % 4;
            @(negedge clk);
            for (int i = 0; i < 4; i++) bus.slot_addr[i] = AW'(((i + 1) << 12) + v);
            bus.LVBL = vecs[v].lvbl;
            bus.slot_cs = vecs[v].cs;
            run_grants(vecs[v].n, got, cnt);
            chk($sformatf("v%0d_count", v), 64'(cnt), 64'(vecs[v].n));
            for (int j = 0; j < vecs[v].n; j++)
                chk($sformatf("v%0d_grant%0d", v, j), 64'(got[j]), 64'(vecs[v].order[j]));
            wait_sig($sformatf("v%0d_fill", v), 3, vecs[v].cs, 60);
            chk($sformatf("v%0d_ok", v), 64'(bus.slot_ok), 64'(vecs[v].cs));
        end

        // Single miss with fixed timing and data
        do_reset();
        use_fixed = 1'b1; fixed_dat = 32'hDEADBEEF; ack_dly = 2; rdy_dly = 3;
        @(negedge clk);
        bus.slot_addr[0] = AW'(22'h00100);
        bus.slot_cs = 4'b0001;
        #4;
        chk("miss_req_idle", 64'(bus.sdram_req), 64'd0);
        chk("miss_refresh_pend", 64'(bus.refresh_en), 64'd0);
        @(negedge clk);
        #4;
        chk("miss_req_t1", 64'(bus.sdram_req), 64'd1);
        chk("miss_addr", 64'(bus.sdram_addr), 64'h100);
        base = n_req;
        wait_sig("miss_rdy", 2, 4'b0, 20);
        chk("miss_ok_at_rdy", 64'(bus.slot_ok[0]), 64'd0);
        @(negedge clk);
        #4;
        chk("miss_ok_after", 64'(bus.slot_ok[0]), 64'd1);
        chk("miss_dout", 64'(bus.slot_dout[0]), 64'hDEADBEEF);
        repeat (10) @(negedge clk);
        #4;
        chk("miss_no_second", 64'(n_req), 64'(base));
        chk("miss_ok_held", 64'(bus.slot_ok[0]), 64'd1);
        use_fixed = 1'b0;

        // Re-miss on the last granted slot waits behind other pending slots
        do_reset();
        ack_dly = 2; rdy_dly = 2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) bus.slot_addr[i] = AW'((i + 1) << 12);
        bus.slot_cs = 4'b0001;
        wait_sig("remiss_first", 3, 4'b0001, 40);
        @(negedge clk);
        for (int i = 0; i < 3; i++) bus.slot_addr[i] = AW'(((i + 1) << 12) + 1);
        bus.slot_cs = 4'b0111;
        run_grants(3, got, cnt);
        chk("remiss_count", 64'(cnt), 64'd3);
        chk("remiss_g0", 64'(got[0]), 64'd1);
        chk("remiss_g1", 64'(got[1]), 64'd2);
        chk("remiss_g2", 64'(got[2]), 64'd0);
        wait_sig("remiss_fill", 3, 4'b0111, 60);

        // Address moves while the fetch is in WAIT
        do_reset();
        ack_dly = 2; rdy_dly = 4;
        @(negedge clk);
        bus.slot_addr[1] = AW'(22'h200);
        bus.slot_cs = 4'b0010;
        wait_sig("move_ack", 1, 4'b0, 20);
        @(negedge clk);
        bus.slot_addr[1] = AW'(22'h300);
        wait_sig("move_rdy", 2, 4'b0, 20);
        @(negedge clk);
        #4;
        chk("move_ok_low", 64'(bus.slot_ok[1]), 64'd0);
        chk("move_dout_old", 64'(bus.slot_dout[1]), 64'(mem(AW'(22'h200))));
        wait_sig("move_req2", 0, 4'b0, 10);
        chk("move_addr2", 64'(bus.sdram_addr), 64'h300);
        wait_sig("move_fill2", 3, 4'b0010, 30);
        chk("move_dout_new", 64'(bus.slot_dout[1]), 64'(mem(AW'(22'h300))));

        // Download blocks fetching
        do_reset();
        @(negedge clk);
        bus.downloading = 1'b1;
        bus.slot_addr[2] = AW'(22'h3333);
        bus.slot_cs = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #4;
            chk("dl_req", 64'(bus.sdram_req), 64'd0);
            chk("dl_refresh", 64'(bus.refresh_en), 64'd1);
            chk("dl_ok", 64'(bus.slot_ok[2]), 64'd0);
        end
        @(negedge clk);
        bus.downloading = 1'b0;
        wait_sig("dl_req_after", 0, 4'b0, 10);
        chk("dl_addr_after", 64'(bus.sdram_addr), 64'h3333);
        wait_sig("dl_fill", 3, 4'b0100, 30);

        // Reset pulse while a request is outstanding
        do_reset();
        ack_dly = 1; rdy_dly = 1;
        @(negedge clk);
        bus.slot_addr[1] = AW'(22'h5555);
        bus.slot_cs = 4'b0010;
        wait_sig("rreq_pre", 3, 4'b0010, 20);
        ack_dly = 8;
        @(negedge clk);
        bus.slot_addr[0] = AW'(22'h4444);
        bus.slot_cs = 4'b0011;
        wait_sig("rreq_req", 0, 4'b0, 10);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rreq_req_low", 64'(bus.sdram_req), 64'd0);
        chk("rreq_ok_low", 64'(bus.slot_ok), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        ack_dly = 2;
        wait_sig("rreq_reissue", 0, 4'b0, 10);
        chk("rreq_addr", 64'(bus.sdram_addr), 64'h4444);
        wait_sig("rreq_fill", 3, 4'b0011, 60);

        // Random traffic against the model
        do_reset();
        base = n_req;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                s = int'($urandom_range(0, 3));
                bus.slot_cs[s]   = ($urandom_range(0, 4) != 0);
                bus.slot_addr[s] = AW'(((s + 1) << 12) + int'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 15) == 0) bus.LVBL = ~bus.LVBL;
            if (bus.downloading) begin
                if ($urandom_range(0, 5) == 0) bus.downloading = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                bus.downloading = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                ack_dly = int'($urandom_range(1, 3));
                rdy_dly = int'($urandom_range(1, 4));
            end
        end
        @(negedge clk);
        bus.downloading = 1'b0;
        chk("rand_activity", 64'(n_req - base > 50), 64'd1);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
